// File: rtl/reg_pkg.sv
// Shared definitions for the storage-register readback serializer.
package reg_pkg;
  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } ser_state_t;
endpackage

// File: rtl/bit_tick.sv
// Bit-rate divider: free-runs 0..CLK_DIV-1 and flags the terminal count.
module bit_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);
  localparam logic [7:0] TERM = 8'(CLK_DIV - 1);

  logic [7:0] cnt_q, cnt_d;

  assign tick = (cnt_q == TERM);

  always_comb begin
    cnt_d = cnt_q + 8'd1;
    if (clear || tick) cnt_d = '0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/reg_word_serializer.sv
// Captures readword on start and shifts it out MSB-first, CLK_DIV cycles per bit,
// framed by sframe and closed by a one-cycle done pulse.
module reg_word_serializer
  import reg_pkg::*;
#(
  parameter int WIDTH   = WORD_W,
  parameter int CLK_DIV = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] readword,
  output logic             busy,
  output logic             sframe,
  output logic             sdata,
  output logic             done
);
  localparam int BCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  ser_state_t       state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [BCW-1:0]   bcnt_q, bcnt_d;
  logic             busy_q, busy_d;
  logic             sframe_q, sframe_d;
  logic             done_q, done_d;
  logic             tick;

  // Divider is held at zero outside SHIFT so every frame starts on a full bit.
  bit_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clock (clock),
    .reset (reset),
    .clear (state_q != SHIFT),
    .tick  (tick)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      bcnt_q   <= '0;
      busy_q   <= 1'b0;
      sframe_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      bcnt_q   <= bcnt_d;
      busy_q   <= busy_d;
      sframe_q <= sframe_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bcnt_d  = bcnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          shift_d = readword;
          bcnt_d  = BCW'(WIDTH - 1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (tick) begin
          if (bcnt_q != '0) begin
            shift_d = {shift_q[WIDTH-2:0], 1'b0};
            bcnt_d  = bcnt_q - BCW'(1);
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Flags are decoded from the next state so they leave the flops with the state.
  always_comb begin
    busy_d   = (state_d != IDLE);
    sframe_d = (state_d == SHIFT);
    done_d   = (state_d == DONE);
  end

  assign busy   = busy_q;
  assign sframe = sframe_q;
  assign done   = done_q;
  assign sdata  = sframe_q & shift_q[WIDTH-1];
endmodule

// File: tb/tb_reg_word_serializer.sv
// Directed bench for reg_word_serializer at CLK_DIV=4 and CLK_DIV=1.
module tb_reg_word_serializer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start4 = 1'b0, start1 = 1'b0;
  logic [15:0] rw4 = '0, rw1 = '0;
  logic        busy4, sframe4, sdata4, done4;
  logic        busy1, sframe1, sdata1, done1;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  reg_word_serializer #(.WIDTH(16), .CLK_DIV(4)) dut4 (
    .clock(clk), .reset(rst_n), .start(start4), .readword(rw4),
    .busy(busy4), .sframe(sframe4), .sdata(sdata4), .done(done4)
  );

  reg_word_serializer #(.WIDTH(16), .CLK_DIV(1)) dut1 (
    .clock(clk), .reset(rst_n), .start(start1), .readword(rw1),
    .busy(busy1), .sframe(sframe1), .sdata(sdata1), .done(done1)
  );

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; start4 = 1'b1; start1 = 1'b1; rw4 = 16'hFFFF; rw1 = 16'hFFFF;
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if ({busy4, sframe4, sdata4, done4} !== 4'b0000) begin
        n_bad++; $display("FAIL reset_hold4 got=%b want=0000", {busy4, sframe4, sdata4, done4});
      end
      n_cmp++;
      if ({busy1, sframe1, sdata1, done1} !== 4'b0000) begin
        n_bad++; $display("FAIL reset_hold1 got=%b want=0000", {busy1, sframe1, sdata1, done1});
      end
    end
    start4 = 1'b0; start1 = 1'b0;
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if ({busy4, sframe4, sdata4, done4, busy1, sframe1, done1} !== 7'b0) begin
        n_bad++; $display("FAIL reset_release got=%b want=0000000",
                          {busy4, sframe4, sdata4, done4, busy1, sframe1, done1});
      end
    end
  endtask

  task automatic test_basic_frame();
    logic [15:0] w;
    logic e_busy, e_fr, e_dat, e_done;
    w = 16'd20;
    @(negedge clk); rw4 = w; start4 = 1'b1;
    @(posedge clk); #1 start4 = 1'b0;
    for (int c = 1; c <= 67; c++) begin
      @(negedge clk);
      e_fr   = (c <= 64);
      e_dat  = e_fr ? w[15 - (c - 1) / 4] : 1'b0;
      e_done = (c == 65);
      e_busy = (c <= 65);
      n_cmp++;
      if ({busy4, sframe4, sdata4, done4} !== {e_busy, e_fr, e_dat, e_done}) begin
        n_bad++;
        $display("FAIL basic_frame cyc=%0d got busy/sframe/sdata/done=%b want=%b",
                 c, {busy4, sframe4, sdata4, done4}, {e_busy, e_fr, e_dat, e_done});
      end
    end
  endtask

  task automatic test_capture_isolation();
    logic [15:0] w;
    logic e_fr, e_dat;
    w = 16'd10;
    @(negedge clk); rw4 = w; start4 = 1'b1;
    @(posedge clk); #1 start4 = 1'b0;
    for (int c = 1; c <= 66; c++) begin
      @(negedge clk);
      e_fr  = (c <= 64);
      e_dat = e_fr ? w[15 - (c - 1) / 4] : 1'b0;
      n_cmp++;
      if ({sframe4, sdata4, done4} !== {e_fr, e_dat, (c == 65)}) begin
        n_bad++;
        $display("FAIL capture_iso cyc=%0d got sframe/sdata/done=%b want=%b",
                 c, {sframe4, sdata4, done4}, {e_fr, e_dat, (c == 65)});
      end
      if (c == 10) rw4 = 16'd30;
    end
  endtask

  task automatic test_busy_ignore();
    logic [15:0] w;
    int dones;
    logic e_fr, e_dat;
    w = 16'h1234;
    dones = 0;
    @(negedge clk); rw4 = w; start4 = 1'b1;
    @(posedge clk); #1 start4 = 1'b0;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      start4 = 1'b0;
      if (done4) dones++;
      e_fr  = (c <= 64);
      e_dat = e_fr ? w[15 - (c - 1) / 4] : 1'b0;
      n_cmp++;
      if ({busy4, sframe4, sdata4} !== {(c <= 65), e_fr, e_dat}) begin
        n_bad++;
        $display("FAIL busy_ignore cyc=%0d got busy/sframe/sdata=%b want=%b",
                 c, {busy4, sframe4, sdata4}, {(c <= 65), e_fr, e_dat});
      end
      if (c == 20 || c == 65) begin
        rw4 = 16'hFFFF; start4 = 1'b1;
      end
    end
    n_cmp++;
    if (dones !== 1) begin
      n_bad++; $display("FAIL busy_ignore_dones got=%0d want=1", dones);
    end
  endtask

  task automatic test_mid_reset();
    logic [15:0] w;
    logic e_fr, e_dat;
    @(negedge clk); rw4 = 16'hFFFF; start4 = 1'b1;
    @(posedge clk); #1 start4 = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (c == 29) begin
        n_cmp++;
        if ({busy4, sframe4, sdata4} !== 3'b111) begin
          n_bad++; $display("FAIL mid_reset_pre got=%b want=111", {busy4, sframe4, sdata4});
        end
      end
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy4, sframe4, sdata4, done4} !== 4'b0000) begin
      n_bad++; $display("FAIL mid_reset_abort got=%b want=0000", {busy4, sframe4, sdata4, done4});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({busy4, done4} !== 2'b00) begin
        n_bad++; $display("FAIL mid_reset_idle got busy/done=%b want=00", {busy4, done4});
      end
    end
    w = 16'h8001;
    rw4 = w; start4 = 1'b1;
    @(posedge clk); #1 start4 = 1'b0;
    for (int c = 1; c <= 66; c++) begin
      @(negedge clk);
      e_fr  = (c <= 64);
      e_dat = e_fr ? w[15 - (c - 1) / 4] : 1'b0;
      n_cmp++;
      if ({busy4, sframe4, sdata4, done4} !== {(c <= 65), e_fr, e_dat, (c == 65)}) begin
        n_bad++;
        $display("FAIL mid_reset_refresh cyc=%0d got=%b want=%b",
                 c, {busy4, sframe4, sdata4, done4}, {(c <= 65), e_fr, e_dat, (c == 65)});
      end
    end
  endtask

  task automatic test_clkdiv1();
    logic [15:0] w;
    logic e_fr, e_dat;
    w = 16'hA5A5;
    @(negedge clk); rw1 = w; start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    for (int c = 1; c <= 19; c++) begin
      @(negedge clk);
      e_fr  = (c <= 16);
      e_dat = e_fr ? w[16 - c] : 1'b0;
      n_cmp++;
      if ({busy1, sframe1, sdata1, done1} !== {(c <= 17), e_fr, e_dat, (c == 17)}) begin
        n_bad++;
        $display("FAIL clkdiv1 cyc=%0d got=%b want=%b",
                 c, {busy1, sframe1, sdata1, done1}, {(c <= 17), e_fr, e_dat, (c == 17)});
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_capture_isolation();
    test_busy_ignore();
    test_mid_reset();
    test_clkdiv1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
